// File: rtl/unified_imem_dmem_if.sv
// Request/response bus between the multicycle controller (master) and the unified memory (slave).
interface unified_imem_dmem_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              resp_iord;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_iord
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_iord
    );
endinterface

// File: rtl/unified_imem_dmem.sv
// Unified byte-addressed instruction/data memory with valid/ready requests and fixed read latency.
// Optional macro UNIFIED_MEM_INIT_EN preloads the instruction region from INIT_IMAGE.
module unified_imem_dmem #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned IMEM_BYTES = 80,
    parameter int unsigned DMEM_BYTES = 944,
    parameter int unsigned READ_LAT   = 1,
    parameter string       INIT_FILE  = "imem.hex",
    parameter logic [8*IMEM_BYTES-1:0] INIT_IMAGE = '0
) (
    input logic              clk,
    input logic              rst_n,
    unified_imem_dmem_if.slave bus
);

    localparam int unsigned TOTAL = IMEM_BYTES + DMEM_BYTES;
    localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned CNT_W = 3;

    if (IMEM_BYTES % 4 != 0) begin : g_chk_imem_align
        $error("IMEM_BYTES must be a multiple of 4");
    end
    if (TOTAL > (1 << ADDR_W)) begin : g_chk_total
        $error("IMEM_BYTES + DMEM_BYTES exceeds the address space");
    end
    if (READ_LAT > 7) begin : g_chk_lat
        $error("READ_LAT must be in 0..7");
    end
    if (ADDR_W < 2) begin : g_chk_addr_w
        $error("ADDR_W must be at least 2");
    end
    if (INIT_FILE == "") begin : g_chk_init_file
        $error("INIT_FILE must name an image");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hold_rdata;
    logic             hold_err;
    logic             hold_iord;

    logic [7:0] mem [TOTAL];

    logic [1:0]      last_off_c;
    logic [ADDR_W:0] last_c;
    logic            misalign_c;
    logic            range_err_c;
    logic            iord_c;
    logic            fault_c;
    logic            accept_c;
    logic [31:0]     raw_c;
    logic [31:0]     ext_c;
    logic [31:0]     rdata_c;

    // Decode the presented request: fault check, region, and extended load data.
    always_comb begin
        case (bus.req_size)
            2'b00:   last_off_c = 2'd0;
            2'b01:   last_off_c = 2'd1;
            default: last_off_c = 2'd3;
        endcase
        last_c      = {1'b0, bus.req_addr} + (ADDR_W+1)'(last_off_c);
        misalign_c  = (bus.req_size == 2'b11)
                    | ((bus.req_size == 2'b01) & bus.req_addr[0])
                    | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
        range_err_c = last_c >= (ADDR_W+1)'(TOTAL);
        iord_c      = {1'b0, bus.req_addr} < (ADDR_W+1)'(IMEM_BYTES);
        fault_c     = misalign_c | range_err_c | (bus.req_we & iord_c);
        accept_c    = bus.req_valid & bus.req_ready & rst_n;

        raw_c = '0;
        for (int k = 0; k < 4; k++) begin
            raw_c[8*k +: 8] = mem[IDX_W'(bus.req_addr + ADDR_W'(k))];
        end

        case (bus.req_size)
            2'b00:   ext_c = bus.req_unsigned ? {24'd0, raw_c[7:0]}
                                              : {{24{raw_c[7]}}, raw_c[7:0]};
            2'b01:   ext_c = bus.req_unsigned ? {16'd0, raw_c[15:0]}
                                              : {{16{raw_c[15]}}, raw_c[15:0]};
            default: ext_c = raw_c;
        endcase
        rdata_c = (fault_c | bus.req_we) ? 32'd0 : ext_c;
    end

    // Store commit on the acceptance edge; the array is never reset.
    always_ff @(posedge clk) begin
        if (accept_c & bus.req_we & ~fault_c) begin
            for (int k = 0; k < 4; k++) begin
                if (2'(k) <= last_off_c) begin
                    mem[IDX_W'(bus.req_addr + ADDR_W'(k))] <= bus.req_wdata[8*k +: 8];
                end
            end
        end
    end

`ifdef UNIFIED_MEM_INIT_EN
    initial begin
        for (int i = int'(IMEM_BYTES); i < int'(TOTAL); i++) begin
            mem[IDX_W'(i)] = 8'h00;
        end
        for (int i = 0; i < int'(IMEM_BYTES); i++) begin
            mem[IDX_W'(i)] = INIT_IMAGE[8*i +: 8];
        end
    end
`endif

    // Request/response sequencer: IDLE -> WAIT (READ_LAT cycles) -> RESP -> IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            hold_rdata     <= '0;
            hold_err       <= 1'b0;
            hold_iord      <= 1'b0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.resp_iord  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    if (accept_c) begin
                        bus.req_ready <= 1'b0;
                        hold_rdata    <= rdata_c;
                        hold_err      <= fault_c;
                        hold_iord     <= iord_c;
                        cnt           <= '0;
                        if (READ_LAT == 0) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= rdata_c;
                            bus.resp_err   <= fault_c;
                            bus.resp_iord  <= iord_c;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(READ_LAT - 1)) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= hold_rdata;
                        bus.resp_err   <= hold_err;
                        bus.resp_iord  <= hold_iord;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
